// File: rtl/restador_serie_ctrl_if.sv
// Requester-side handshake and result bus of the bit-serial subtraction controller.
interface restador_serie_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/restador_serie_ctrl.sv
// Bit-serial subtractor: one shared full-subtractor cell sequenced LSB first over WIDTH cycles.
// Produces diff = A - B mod 2^WIDTH and the final borrow (A < B).
module restador_serie_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic r_c,
    output logic bout_c
);
    assign r_c    = x ^ y ^ bin;
    assign bout_c = (~x & y) | (~(x ^ y) & bin);
endmodule

module restador_serie_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    restador_serie_ctrl_if.slave  bus
);
    // Counter must be able to hold the value WIDTH itself.
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             cell_r;
    logic             cell_bout;

    restador_serie_cell u_cell (
        .x      (sa[0]),
        .y      (sb[0]),
        .bin    (brw),
        .r_c    (cell_r),
        .bout_c (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand shift registers, result accumulation and running borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            res <= '0;
            brw <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        brw <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {cell_r, res[WIDTH-1:1]};
                    brw <= cell_bout;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Results publish once per job and hold until the next job completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.diff   <= '0;
            bus.borrow <= 1'b0;
        end else begin
            bus.busy <= (state_n == RUN);
            bus.done <= (state == DONE);
            if (state == DONE) begin
                bus.diff   <= res;
                bus.borrow <= brw;
            end
        end
    end
endmodule

// File: tb/tb_restador_serie_ctrl.sv
// Self-checking bench: directed and random jobs on WIDTH=8 and WIDTH=13 instances
// against an arithmetic reference model.
module tb_restador_serie_ctrl;
    localparam int unsigned W0 = 8;
    localparam int unsigned W1 = 13;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] prev_diff [2];

    always #5 clk = ~clk;

    restador_serie_ctrl_if #(.WIDTH(W0)) if8 ();
    restador_serie_ctrl_if #(.WIDTH(W1)) if13 ();

    restador_serie_ctrl #(.WIDTH(W0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    restador_serie_ctrl #(.WIDTH(W1)) dut13 (.clk(clk), .rst_n(rst_n), .bus(if13));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {borrow,diff} = {0,a} - {0,b} at width w.
    function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = {16'b0, a} - {16'b0, b};
        return {full[w], 16'(full & ((32'd1 << w) - 32'd1))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic st, input logic [15:0] a, input logic [15:0] b);
        if (s == 0) begin
            if8.start = st; if8.a = a[7:0]; if8.b = b[7:0];
        end else begin
            if13.start = st; if13.a = a[12:0]; if13.b = b[12:0];
        end
    endtask

    task automatic sample(input int s, output logic bz, output logic dn,
                          output logic [15:0] df, output logic br);
        if (s == 0) begin
            bz = if8.busy; dn = if8.done; df = 16'(if8.diff); br = if8.borrow;
        end else begin
            bz = if13.busy; dn = if13.done; df = 16'(if13.diff); br = if13.borrow;
        end
    endtask

    // One job from IDLE: checks latency, busy length, hold, result and single-cycle done.
    task automatic job(input int s, input logic [15:0] a, input logic [15:0] b,
                       input bit poke, input string tag);
        int          w;
        int          nbusy;
        int          early;
        int          overlap;
        logic [16:0] exp;
        logic        bz, dn, br;
        logic [15:0] df;
        w       = (s == 0) ? int'(W0) : int'(W1);
        exp     = model(w, a, b);
        nbusy   = 0;
        early   = 0;
        overlap = 0;
        @(negedge clk);
        drive(s, 1'b1, a, b);
        tick();
        drive(s, 1'b0, 16'($urandom), 16'($urandom));
        for (int k = 0; k <= w + 1; k++) begin
            sample(s, bz, dn, df, br);
            nbusy   += int'(bz);
            overlap += int'(bz & dn);
            if (k <= w) early += int'(dn);
            if (k == w / 2) check({tag, "_hold"}, 32'(df), 32'(prev_diff[s]));
            if (k <= w) begin
                if (poke && (k == 3 || k == w)) begin
                    @(negedge clk);
                    drive(s, 1'b1, 16'($urandom), 16'($urandom));
                end
                tick();
                drive(s, 1'b0, 16'($urandom), 16'($urandom));
            end
        end
        check({tag, "_done"}, 32'(dn), 32'd1);
        check({tag, "_diff"}, 32'(df), 32'(exp[15:0]));
        check({tag, "_borrow"}, 32'(br), 32'(exp[16]));
        check({tag, "_busy_len"}, 32'(nbusy), 32'(w));
        check({tag, "_early_done"}, 32'(early), 32'd0);
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        tick();
        sample(s, bz, dn, df, br);
        check({tag, "_done_pulse"}, 32'(dn), 32'd0);
        if (poke) check({tag, "_start_ignored"}, 32'(bz), 32'd0);
        prev_diff[s] = exp[15:0];
    endtask

    initial begin
        logic        bz, dn, br;
        logic [15:0] df;
        logic [16:0] exp;
        logic [7:0]  ca [3];
        logic [7:0]  cb [3];
        int          nb, nd;
        logic [15:0] ra, rb;

        prev_diff[0] = '0;
        prev_diff[1] = '0;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        rst_n = 1'b0;
        #12;
        sample(0, bz, dn, df, br);
        check("reset_busy", 32'(bz), 32'd0);
        check("reset_done", 32'(dn), 32'd0);
        check("reset_diff", 32'(df), 32'd0);
        check("reset_borrow", 32'(br), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        job(0, 16'h5A, 16'h23, 1'b0, "d5a_23");
        job(0, 16'h00, 16'hFF, 1'b0, "d00_ff");
        job(0, 16'h80, 16'h80, 1'b0, "d80_80");
        job(0, 16'hFF, 16'h00, 1'b0, "dff_00");
        job(0, 16'h13, 16'hA7, 1'b1, "dpoke");

        // Start held high across three jobs: one done every 10 cycles.
        ca = '{8'h5A, 8'h00, 8'hC3};
        cb = '{8'h23, 8'hFF, 8'h3C};
        for (int j = 0; j < 3; j++) begin
            exp = model(int'(W0), 16'(ca[j]), 16'(cb[j]));
            @(negedge clk);
            drive(0, 1'b1, 16'(ca[j]), 16'(cb[j]));
            tick();
            nb = 0;
            nd = 0;
            for (int k = 0; k <= 9; k++) begin
                sample(0, bz, dn, df, br);
                nb += int'(bz);
                nd += int'(dn);
                if (k < 9) begin
                    drive(0, 1'b1, 16'($urandom), 16'($urandom));
                    tick();
                end
            end
            check("cont_done_at_9", 32'(dn), 32'd1);
            check("cont_done_count", 32'(nd), 32'd1);
            check("cont_busy_len", 32'(nb), 32'd8);
            check("cont_diff", 32'(df), 32'(exp[15:0]));
            check("cont_borrow", 32'(br), 32'(exp[16]));
            prev_diff[0] = exp[15:0];
        end
        @(negedge clk);
        drive(0, 1'b0, '0, '0);
        tick();
        sample(0, bz, dn, df, br);
        check("cont_stop_idle", 32'(bz), 32'd0);
        tick();

        // Asynchronous reset in the middle of a job.
        @(negedge clk);
        drive(0, 1'b1, 16'h5A, 16'h23);
        tick();
        drive(0, 1'b0, '0, '0);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        sample(0, bz, dn, df, br);
        check("midrun_rst_busy", 32'(bz), 32'd0);
        check("midrun_rst_done", 32'(dn), 32'd0);
        check("midrun_rst_diff", 32'(df), 32'd0);
        check("midrun_rst_borrow", 32'(br), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            sample(0, bz, dn, df, br);
            nd += int'(dn);
            nb += int'(bz);
        end
        check("midrun_no_done", 32'(nd), 32'd0);
        check("midrun_no_busy", 32'(nb), 32'd0);
        prev_diff[0] = '0;
        prev_diff[1] = '0;

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom) & 16'h00FF;
            rb = (i % 10 == 0) ? ra : (16'($urandom) & 16'h00FF);
            repeat ($urandom_range(0, 2)) tick();
            job(0, ra, rb, (i % 50 == 0), "rnd8");
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom) & 16'h1FFF;
            rb = (i % 10 == 0) ? ra : (16'($urandom) & 16'h1FFF);
            repeat ($urandom_range(0, 2)) tick();
            job(1, ra, rb, (i % 50 == 0), "rnd13");
        end
        job(1, 16'h0000, 16'h1FFF, 1'b0, "d13_0_max");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
